// File: rtl/cu_power_sequencer.sv
// Power sequencer for one kernel launch: brings up L2, releases the selected CUs,
// gates each CU once it asks to sleep and its L2 traffic has drained, then gates L2.
module cu_power_sequencer #(
    parameter int NUM_CUS      = 4,
    parameter int RST_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_CUS-1:0] cu_mask_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic [NUM_CUS-1:0] cu_sleep_req_i,
    input  logic [NUM_CUS-1:0] cu_delay_sleep_i,
    input  logic               l2_idle_i,
    output logic [NUM_CUS-1:0] cu_clk_en_o,
    output logic [NUM_CUS-1:0] cu_rst_n_o,
    output logic               l2_clk_en_o,
    output logic               l2_rst_n_o
);

    localparam int CNT_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

    typedef enum logic [2:0] {G_IDLE, G_L2_RST, G_RUN, G_L2_DRAIN, G_FINISH} g_state_t;
    typedef enum logic [2:0] {C_OFF, C_RST, C_RUN, C_DRAIN, C_SLEEP} cu_state_t;

    g_state_t           g_state_q, g_state_d;
    logic [CW-1:0]      g_cnt_q, g_cnt_d;
    logic [NUM_CUS-1:0] mask_q, mask_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               l2_clk_en_q, l2_clk_en_d;
    logic               l2_rst_n_q, l2_rst_n_d;
    logic               run_entry;
    logic               finish_now;
    logic [NUM_CUS-1:0] cu_asleep;

    always_comb begin
        g_state_d = g_state_q;
        g_cnt_d   = g_cnt_q;
        mask_d    = mask_q;
        done_d    = 1'b0;
        run_entry = 1'b0;
        case (g_state_q)
            G_IDLE: begin
                g_cnt_d = '0;
                if (start_i) begin
                    mask_d = cu_mask_i;
                    if (cu_mask_i == '0) done_d = 1'b1;
                    else                 g_state_d = G_L2_RST;
                end
            end
            G_L2_RST: begin
                if (g_cnt_q == RST_LAST) begin
                    g_state_d = G_RUN;
                    g_cnt_d   = '0;
                    run_entry = 1'b1;
                end else if (g_cnt_q != CNT_SAT) begin
                    g_cnt_d = g_cnt_q + 1'b1;
                end
            end
            G_RUN: begin
                // Unlaunched CUs never sleep, so they are masked out of the check
                if (&(cu_asleep | ~mask_q)) g_state_d = G_L2_DRAIN;
            end
            G_L2_DRAIN: begin
                if (l2_idle_i) begin
                    g_state_d = G_FINISH;
                    done_d    = 1'b1;
                end
            end
            G_FINISH: g_state_d = G_IDLE;
            default:  g_state_d = G_IDLE;
        endcase
        busy_d      = (g_state_d != G_IDLE);
        l2_clk_en_d = (g_state_d != G_IDLE);
        l2_rst_n_d  = (g_state_d inside {G_RUN, G_L2_DRAIN, G_FINISH});
    end

    assign finish_now = (g_state_q == G_FINISH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            g_state_q   <= G_IDLE;
            g_cnt_q     <= '0;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            l2_clk_en_q <= 1'b0;
            l2_rst_n_q  <= 1'b0;
        end else begin
            g_state_q   <= g_state_d;
            g_cnt_q     <= g_cnt_d;
            mask_q      <= mask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            l2_clk_en_q <= l2_clk_en_d;
            l2_rst_n_q  <= l2_rst_n_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign l2_clk_en_o = l2_clk_en_q;
    assign l2_rst_n_o  = l2_rst_n_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CUS; gi++) begin : g_cu
            cu_state_t     st_q, st_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          clk_en_q, rst_n_q;

            always_comb begin
                st_d  = st_q;
                cnt_d = cnt_q;
                if (finish_now) begin
                    st_d  = C_OFF;
                    cnt_d = '0;
                end else begin
                    case (st_q)
                        C_OFF: begin
                            cnt_d = '0;
                            if (run_entry && mask_q[gi]) st_d = C_RST;
                        end
                        C_RST: begin
                            if (cnt_q == RST_LAST) begin
                                st_d  = C_RUN;
                                cnt_d = '0;
                            end else if (cnt_q != CNT_SAT) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        C_RUN: begin
                            cnt_d = '0;
                            if (cu_sleep_req_i[gi]) st_d = C_DRAIN;
                        end
                        C_DRAIN: begin
                            // Counter tracks consecutive quiet cycles; any traffic restarts it
                            if (!cu_sleep_req_i[gi]) begin
                                st_d  = C_RUN;
                                cnt_d = '0;
                            end else if (cu_delay_sleep_i[gi]) begin
                                cnt_d = '0;
                            end else if (cnt_q == DRAIN_LAST) begin
                                st_d  = C_SLEEP;
                                cnt_d = '0;
                            end else if (cnt_q != CNT_SAT) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        C_SLEEP: cnt_d = '0;
                        default: begin
                            st_d  = C_OFF;
                            cnt_d = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    st_q     <= C_OFF;
                    cnt_q    <= '0;
                    clk_en_q <= 1'b0;
                    rst_n_q  <= 1'b0;
                end else begin
                    st_q     <= st_d;
                    cnt_q    <= cnt_d;
                    clk_en_q <= (st_d inside {C_RST, C_RUN, C_DRAIN});
                    rst_n_q  <= (st_d inside {C_RUN, C_DRAIN, C_SLEEP});
                end
            end

            assign cu_asleep[gi]   = (st_q == C_SLEEP);
            assign cu_clk_en_o[gi] = clk_en_q;
            assign cu_rst_n_o[gi]  = rst_n_q;
        end
    endgenerate

endmodule

// File: tb/tb_cu_power_sequencer.sv
// Directed bench for cu_power_sequencer: launch timing, CU drain/sleep, L2 drain/finish,
// empty launch, ignored restart and mid-run reset.
module tb_cu_power_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [3:0] cu_mask_i;
    logic       busy_o;
    logic       done_o;
    logic [3:0] cu_sleep_req_i;
    logic [3:0] cu_delay_sleep_i;
    logic       l2_idle_i;
    logic [3:0] cu_clk_en_o;
    logic [3:0] cu_rst_n_o;
    logic       l2_clk_en_o;
    logic       l2_rst_n_o;

    int total = 0;
    int bad   = 0;

    cu_power_sequencer #(
        .NUM_CUS(4), .RST_CYCLES(4), .DRAIN_CYCLES(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cu_mask_i(cu_mask_i),
        .busy_o(busy_o), .done_o(done_o), .cu_sleep_req_i(cu_sleep_req_i),
        .cu_delay_sleep_i(cu_delay_sleep_i), .l2_idle_i(l2_idle_i),
        .cu_clk_en_o(cu_clk_en_o), .cu_rst_n_o(cu_rst_n_o),
        .l2_clk_en_o(l2_clk_en_o), .l2_rst_n_o(l2_rst_n_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; outputs are observed 1ns after the edge, inputs driven there too.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
        outs = {busy_o, done_o, l2_clk_en_o, l2_rst_n_o, cu_clk_en_o, cu_rst_n_o};
        total++;
        if (outs !== 12'h000) begin bad++; $display("FAIL reset_outputs: got %h want %h", outs, 12'h000); end
        $display("reset: outputs=%h", outs);
    endtask

    // Launch with mask 0101; a second start with 1111 while busy must be ignored.
    task automatic test_launch();
        start_i = 1'b1; cu_mask_i = 4'b0101;
        step();                                   // t+1
        start_i = 1'b0; cu_mask_i = 4'b0000;
        total++;
        if (l2_clk_en_o !== 1'b1) begin bad++; $display("FAIL l2_clk_en_t1: got %b want 1", l2_clk_en_o); end
        total++;
        if ({busy_o, l2_rst_n_o, cu_clk_en_o} !== 6'b100000) begin
            bad++; $display("FAIL launch_t1: got %b want %b", {busy_o, l2_rst_n_o, cu_clk_en_o}, 6'b100000);
        end
        start_i = 1'b1; cu_mask_i = 4'b1111;
        step();                                   // t+2
        start_i = 1'b0; cu_mask_i = 4'b0000;
        step();
        step();                                   // t+4
        total++;
        if (l2_rst_n_o !== 1'b0) begin bad++; $display("FAIL l2_rst_n_t4: got %b want 0", l2_rst_n_o); end
        step();                                   // t+5
        total++;
        if (l2_rst_n_o !== 1'b1) begin bad++; $display("FAIL l2_rst_n_t5: got %b want 1", l2_rst_n_o); end
        total++;
        if (cu_clk_en_o !== 4'b0101) begin bad++; $display("FAIL cu_clk_en_t5: got %b want 0101", cu_clk_en_o); end
        total++;
        if (cu_rst_n_o !== 4'b0000) begin bad++; $display("FAIL cu_rst_n_t5: got %b want 0000", cu_rst_n_o); end
        step(); step(); step();                   // t+8
        total++;
        if (cu_rst_n_o !== 4'b0000) begin bad++; $display("FAIL cu_rst_n_t8: got %b want 0000", cu_rst_n_o); end
        step();                                   // t+9
        total++;
        if ({cu_clk_en_o, cu_rst_n_o} !== 8'b0101_0101) begin
            bad++; $display("FAIL cu_release_t9: got %b want %b", {cu_clk_en_o, cu_rst_n_o}, 8'b0101_0101);
        end
        $display("launch: cu_clk_en=%b cu_rst_n=%b l2=%b%b", cu_clk_en_o, cu_rst_n_o, l2_clk_en_o, l2_rst_n_o);
    endtask

    // CU0: sleep with traffic for 3 cycles, one quiet cycle, a 1-cycle glitch, then quiet.
    task automatic test_cu_drain();
        cu_sleep_req_i = 4'b0001; cu_delay_sleep_i = 4'b0001;   // c0
        step(); step(); step();                                  // c0+3
        cu_delay_sleep_i = 4'b0000;
        step();                                                  // c0+4
        cu_delay_sleep_i = 4'b0001;
        step();                                                  // c0+5
        cu_delay_sleep_i = 4'b0000;
        total++;
        if (cu_clk_en_o[0] !== 1'b1) begin bad++; $display("FAIL glitch_restart: got %b want 1", cu_clk_en_o[0]); end
        step();                                                  // c0+6
        total++;
        if (cu_clk_en_o[0] !== 1'b1) begin bad++; $display("FAIL drain_c6: got %b want 1", cu_clk_en_o[0]); end
        step();                                                  // c0+7
        total++;
        if ({cu_clk_en_o, cu_rst_n_o} !== 8'b0100_0101) begin
            bad++; $display("FAIL cu0_sleep: got %b want %b", {cu_clk_en_o, cu_rst_n_o}, 8'b0100_0101);
        end
        total++;
        if ({busy_o, done_o} !== 2'b10) begin bad++; $display("FAIL busy_one_asleep: got %b want 10", {busy_o, done_o}); end
        $display("cu_drain: cu_clk_en=%b", cu_clk_en_o);
    endtask

    // CU2: sleep request withdrawn mid-drain returns to RUN, then a clean drain.
    task automatic test_drop_req();
        cu_sleep_req_i = 4'b0101;                                // a
        step(); step();                                          // a+2
        cu_sleep_req_i = 4'b0001;
        step();                                                  // a+3
        total++;
        if (cu_clk_en_o !== 4'b0100) begin bad++; $display("FAIL drop_to_run: got %b want 0100", cu_clk_en_o); end
        cu_sleep_req_i = 4'b0101;
        step(); step();                                          // a+5
        total++;
        if (cu_clk_en_o !== 4'b0100) begin bad++; $display("FAIL redrain_a5: got %b want 0100", cu_clk_en_o); end
        step();                                                  // a+6
        total++;
        if (cu_clk_en_o !== 4'b0000) begin bad++; $display("FAIL cu2_sleep: got %b want 0000", cu_clk_en_o); end
        $display("drop_req: cu_clk_en=%b", cu_clk_en_o);
    endtask

    // All launched CUs asleep at cycle k; L2 busy for 5 cycles then idle.
    task automatic test_finish();
        l2_idle_i = 1'b0;
        for (int i = 0; i < 5; i++) begin                        // k .. k+4
            total++;
            if (done_o !== 1'b0) begin bad++; $display("FAIL done_early_%0d: got %b want 0", i, done_o); end
            step();
        end
        l2_idle_i = 1'b1;                                        // k+5
        total++;
        if ({busy_o, done_o, l2_clk_en_o} !== 3'b101) begin
            bad++; $display("FAIL pre_finish: got %b want 101", {busy_o, done_o, l2_clk_en_o});
        end
        step();                                                  // k+6
        total++;
        if ({busy_o, done_o, l2_clk_en_o, l2_rst_n_o} !== 4'b1111) begin
            bad++; $display("FAIL finish_cycle: got %b want 1111", {busy_o, done_o, l2_clk_en_o, l2_rst_n_o});
        end
        step();                                                  // k+7
        total++;
        if ({busy_o, done_o, l2_clk_en_o, l2_rst_n_o, cu_clk_en_o, cu_rst_n_o} !== 12'h000) begin
            bad++; $display("FAIL after_finish: got %b want 0", {busy_o, done_o, l2_clk_en_o, l2_rst_n_o, cu_clk_en_o, cu_rst_n_o});
        end
        cu_sleep_req_i = 4'b0000; l2_idle_i = 1'b0;
        step();                                                  // k+8
        total++;
        if (done_o !== 1'b0) begin bad++; $display("FAIL done_single_pulse: got %b want 0", done_o); end
        $display("finish: busy=%b l2_clk_en=%b", busy_o, l2_clk_en_o);
    endtask

    task automatic test_mask_zero();
        start_i = 1'b1; cu_mask_i = 4'b0000;
        step();
        start_i = 1'b0;
        total++;
        if ({done_o, busy_o, l2_clk_en_o} !== 3'b100) begin
            bad++; $display("FAIL mask_zero_done: got %b want 100", {done_o, busy_o, l2_clk_en_o});
        end
        step();
        total++;
        if ({done_o, busy_o, l2_clk_en_o} !== 3'b000) begin
            bad++; $display("FAIL mask_zero_after: got %b want 000", {done_o, busy_o, l2_clk_en_o});
        end
        $display("mask_zero: done=%b busy=%b", done_o, busy_o);
    endtask

    task automatic test_mid_reset();
        int n;
        start_i = 1'b1; cu_mask_i = 4'b0011;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) step();                      // t+9
        cu_sleep_req_i = 4'b0010; cu_delay_sleep_i = 4'b0010;
        step(); step();
        total++;
        if (cu_clk_en_o !== 4'b0011) begin bad++; $display("FAIL pre_reset_run: got %b want 0011", cu_clk_en_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; cu_sleep_req_i = 4'b0000; cu_delay_sleep_i = 4'b0000;
        total++;
        if ({busy_o, done_o, l2_clk_en_o, l2_rst_n_o, cu_clk_en_o, cu_rst_n_o} !== 12'h000) begin
            bad++; $display("FAIL mid_reset: got %b want 0", {busy_o, done_o, l2_clk_en_o, l2_rst_n_o, cu_clk_en_o, cu_rst_n_o});
        end
        start_i = 1'b1; cu_mask_i = 4'b1000;
        step();                                                  // t+1
        start_i = 1'b0;
        total++;
        if ({busy_o, l2_clk_en_o, l2_rst_n_o} !== 3'b110) begin
            bad++; $display("FAIL relaunch_t1: got %b want 110", {busy_o, l2_clk_en_o, l2_rst_n_o});
        end
        step(); step(); step(); step();                          // t+5
        total++;
        if ({l2_rst_n_o, cu_clk_en_o, cu_rst_n_o} !== 9'b1_1000_0000) begin
            bad++; $display("FAIL relaunch_t5: got %b want %b", {l2_rst_n_o, cu_clk_en_o, cu_rst_n_o}, 9'b1_1000_0000);
        end
        step(); step(); step(); step();                          // t+9
        total++;
        if (cu_rst_n_o !== 4'b1000) begin bad++; $display("FAIL relaunch_t9: got %b want 1000", cu_rst_n_o); end
        cu_sleep_req_i = 4'b1000; l2_idle_i = 1'b1;              // s
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done_o === 1'b1) begin n = i; break; end
        end
        total++;
        if (n != 5) begin bad++; $display("FAIL relaunch_done_latency: got %0d want 5", n); end
        cu_sleep_req_i = 4'b0000; l2_idle_i = 1'b0;
        step();
        total++;
        if ({busy_o, l2_clk_en_o, cu_clk_en_o} !== 6'b000000) begin
            bad++; $display("FAIL relaunch_idle: got %b want 000000", {busy_o, l2_clk_en_o, cu_clk_en_o});
        end
        $display("mid_reset: done after %0d cycles", n);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; cu_mask_i = 4'b0000;
        cu_sleep_req_i = 4'b0000; cu_delay_sleep_i = 4'b0000; l2_idle_i = 1'b0;
        test_reset();
        test_launch();
        test_cu_drain();
        test_drop_req();
        test_finish();
        test_mask_zero();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
